// File: rtl/gpio_mux_bank_if.sv
// gpio_mux_bank_if: source, select-write and output bundle of gpio_mux_bank.
// master drives sources and strobes; slave is the mux bank.
interface gpio_mux_bank_if #(
   parameter int NUM_CH  = 8,
   parameter int NUM_SRC = 4,
   parameter int SEL_W   = 2
);
   logic [NUM_CH*NUM_SRC-1:0] src_in;
   logic [NUM_CH-1:0]         sel_wr;
   logic [SEL_W-1:0]          sel_wdata;
   logic [NUM_CH*SEL_W-1:0]   sel_q;
   logic [NUM_CH-1:0]         mux_out;
   logic [NUM_CH-1:0]         switching;

   modport master (
      output src_in, sel_wr, sel_wdata,
      input  sel_q, mux_out, switching
   );

   modport slave (
      input  src_in, sel_wr, sel_wdata,
      output sel_q, mux_out, switching
   );
endinterface

// File: rtl/gpio_mux_bank.sv
// gpio_mux_bank: per-channel registered source mux with select dead-time.
// Define GPIO_MUX_SYNC_EN to add a two-flop synchronizer on src_in.
module gpio_mux_bank #(
   parameter int   NUM_CH      = 8,
   parameter int   NUM_SRC     = 4,
   parameter int   SEL_W       = 2,
   parameter int   DEAD_CYCLES = 4,
   parameter int   RESET_SEL   = 0,
   parameter logic IDLE_LEVEL  = 1'b0
) (
   input logic            clk,
   input logic            resetn,
   gpio_mux_bank_if.slave bus
);
   localparam int SRC_W = NUM_CH * NUM_SRC;
   localparam int PAD_W = 1 << SEL_W;
   localparam logic [SEL_W-1:0] RST_SEL = SEL_W'(RESET_SEL);
   localparam logic [SEL_W:0]   NSRC    = (SEL_W+1)'(NUM_SRC);
   localparam logic [7:0]       DEAD    = 8'(DEAD_CYCLES);
   localparam bit               HAS_GAP = (DEAD_CYCLES != 0);

   typedef enum logic {ACTIVE, GAP} state_e;

   logic [SRC_W-1:0] src_m;

`ifdef GPIO_MUX_SYNC_EN
   logic [SRC_W-1:0] sync1_q;
   logic [SRC_W-1:0] sync2_q;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         sync1_q <= {SRC_W{IDLE_LEVEL}};
         sync2_q <= {SRC_W{IDLE_LEVEL}};
      end else begin
         sync1_q <= bus.src_in;
         sync2_q <= sync1_q;
      end
   end

   assign src_m = sync2_q;
`else
   assign src_m = bus.src_in;
`endif

   state_e           state_q [NUM_CH];
   state_e           state_d [NUM_CH];
   logic [SEL_W-1:0] selr_q  [NUM_CH];
   logic [SEL_W-1:0] selr_d  [NUM_CH];
   logic [7:0]       cnt_q   [NUM_CH];
   logic [7:0]       cnt_d   [NUM_CH];
   logic [NUM_CH-1:0] out_q;
   logic [NUM_CH-1:0] out_d;

   logic [PAD_W-1:0] src_ch [NUM_CH];
   logic             wr_ok;

   // Pad each channel's sources to 2**SEL_W so the select indexes exactly
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         src_ch[c] = '0;
         src_ch[c][NUM_SRC-1:0] = src_m[c*NUM_SRC +: NUM_SRC];
      end
   end

   assign wr_ok = {1'b0, bus.sel_wdata} < NSRC;

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         state_d[c] = state_q[c];
         selr_d[c]  = selr_q[c];
         cnt_d[c]   = cnt_q[c];
         out_d[c]   = IDLE_LEVEL;
         unique case (state_q[c])
            ACTIVE: begin
               out_d[c] = src_ch[c][selr_q[c]];
               if (bus.sel_wr[c] && wr_ok &&
                   bus.sel_wdata != selr_q[c]) begin
                  selr_d[c] = bus.sel_wdata;
                  if (HAS_GAP) begin
                     state_d[c] = GAP;
                     cnt_d[c]   = DEAD;
                     out_d[c]   = IDLE_LEVEL;
                  end
               end
            end
            GAP: begin
               if (bus.sel_wr[c] && wr_ok) begin
                  selr_d[c] = bus.sel_wdata;
                  cnt_d[c]  = DEAD;
               end else if (cnt_q[c] == 8'd1) begin
                  state_d[c] = ACTIVE;
                  cnt_d[c]   = 8'd0;
                  out_d[c]   = src_ch[c][selr_q[c]];
               end else begin
                  cnt_d[c] = cnt_q[c] - 8'd1;
               end
            end
            default: begin
               state_d[c] = ACTIVE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int c = 0; c < NUM_CH; c++) begin
            state_q[c] <= ACTIVE;
            selr_q[c]  <= RST_SEL;
            cnt_q[c]   <= 8'd0;
         end
         out_q <= {NUM_CH{IDLE_LEVEL}};
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            state_q[c] <= state_d[c];
            selr_q[c]  <= selr_d[c];
            cnt_q[c]   <= cnt_d[c];
         end
         out_q <= out_d;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_out
      assign bus.sel_q[g*SEL_W +: SEL_W] = selr_q[g];
      assign bus.switching[g] = (state_q[g] == GAP);
   end

   assign bus.mux_out = out_q;

endmodule

// File: tb/tb_gpio_mux_bank.sv
// tb_gpio_mux_bank: directed checks of gpio_mux_bank with dead-time 4
// plus a dead-time-free instance.
module tb_gpio_mux_bank;
`ifdef GPIO_MUX_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic clk;
   logic resetn;
   int   n_checks;
   int   n_errors;
   int   first;

   gpio_mux_bank_if #(.NUM_CH(8), .NUM_SRC(4), .SEL_W(3)) bus ();
   gpio_mux_bank_if #(.NUM_CH(2), .NUM_SRC(4), .SEL_W(3)) b0 ();

   gpio_mux_bank #(
      .NUM_CH(8), .NUM_SRC(4), .SEL_W(3), .DEAD_CYCLES(4),
      .RESET_SEL(0), .IDLE_LEVEL(1'b0)
   ) dut (
      .clk(clk), .resetn(resetn), .bus(bus)
   );

   gpio_mux_bank #(
      .NUM_CH(2), .NUM_SRC(4), .SEL_W(3), .DEAD_CYCLES(0),
      .RESET_SEL(0), .IDLE_LEVEL(1'b0)
   ) dut0 (
      .clk(clk), .resetn(resetn), .bus(b0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      resetn = 1'b0;
      bus.src_in = '0;
      bus.sel_wr = '0;
      bus.sel_wdata = '0;
      b0.src_in = '0;
      b0.sel_wr = '0;
      b0.sel_wdata = '0;

      // reset with toggling sources
      for (int i = 0; i < 3; i++) begin
         bus.src_in = (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h0;
         tick();
         check("rst_mux", 32'(bus.mux_out), 32'h0);
         check("rst_sw", 32'(bus.switching), 32'h0);
         check("rst_sel", 32'(bus.sel_q), 32'h0);
      end
      bus.src_in = 32'h0101_1010;
      resetn = 1'b1;
      for (int i = 0; i < LAT; i++) tick();
      check("rel_mux", 32'(bus.mux_out), 32'h5A);
      check("rel_sw", 32'(bus.switching), 32'h0);

      // dead-time on channel 2: src0=1, src3=1
      bus.src_in = 32'h0000_0900;
      for (int i = 0; i < LAT; i++) tick();
      check("c2_pre", 32'(bus.mux_out), 32'h04);
      bus.sel_wr = 8'h04;
      bus.sel_wdata = 3'd3;
      tick();
      bus.sel_wr = '0;
      check("c2_sel", 32'(bus.sel_q[6 +: 3]), 32'd3);
      check("c2_gap_m0", 32'(bus.mux_out), 32'h00);
      check("c2_gap_s0", 32'(bus.switching), 32'h04);
      for (int i = 1; i < 4; i++) begin
         tick();
         check("c2_gap_m", 32'(bus.mux_out), 32'h00);
         check("c2_gap_s", 32'(bus.switching), 32'h04);
      end
      tick();
      check("c2_new", 32'(bus.mux_out), 32'h04);
      check("c2_new_sw", 32'(bus.switching), 32'h00);
      bus.src_in = 32'h0000_0100;
      tick();
      check("c2_src3", 32'(bus.mux_out), 32'h00);

      // same-select write and invalid write on channel 5
      bus.src_in = 32'h0010_0000;
      bus.sel_wr = 8'h20;
      bus.sel_wdata = 3'd0;
      tick();
      bus.sel_wr = '0;
      check("c5_same_m", 32'(bus.mux_out), 32'h20);
      check("c5_same_s", 32'(bus.switching), 32'h00);
      bus.src_in = 32'h0;
      tick();
      check("c5_track", 32'(bus.mux_out), 32'h00);
      bus.src_in = 32'h0010_0000;
      bus.sel_wr = 8'h20;
      bus.sel_wdata = 3'd4;
      tick();
      bus.sel_wr = '0;
      check("c5_inv_s", 32'(bus.switching), 32'h00);
      check("c5_inv_m", 32'(bus.mux_out), 32'h20);
      check("c5_inv_sel", 32'(bus.sel_q), 32'h0000C0);

      // restart dead-time on channel 1
      bus.src_in = 32'h0010_0050;
      tick();
      check("c1_pre", 32'(bus.mux_out), 32'h22);
      bus.sel_wr = 8'h02;
      bus.sel_wdata = 3'd1;
      tick();
      bus.sel_wr = '0;
      check("c1_w0_m", 32'(bus.mux_out), 32'h20);
      check("c1_w0_s", 32'(bus.switching), 32'h02);
      tick();
      check("c1_e1_m", 32'(bus.mux_out), 32'h20);
      check("c1_e1_s", 32'(bus.switching), 32'h02);
      bus.sel_wr = 8'h02;
      bus.sel_wdata = 3'd2;
      tick();
      bus.sel_wr = '0;
      check("c1_re_sel", 32'(bus.sel_q[3 +: 3]), 32'd2);
      check("c1_e2_m", 32'(bus.mux_out), 32'h20);
      check("c1_e2_s", 32'(bus.switching), 32'h02);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("c1_gap_m", 32'(bus.mux_out), 32'h20);
         check("c1_gap_s", 32'(bus.switching), 32'h02);
      end
      tick();
      check("c1_end_m", 32'(bus.mux_out), 32'h22);
      check("c1_end_s", 32'(bus.switching), 32'h00);
      bus.src_in = 32'h0010_0040;
      tick();
      check("c1_src2", 32'(bus.mux_out), 32'h22);

      // simultaneous strobes on channels 0 and 7
      bus.src_in = 32'h3010_0043;
      tick();
      check("c07_pre", 32'(bus.mux_out), 32'hA3);
      bus.sel_wr = 8'h81;
      bus.sel_wdata = 3'd1;
      tick();
      bus.sel_wr = '0;
      check("c07_sel", 32'(bus.sel_q), 32'h2000D1);
      check("c07_m0", 32'(bus.mux_out), 32'h22);
      check("c07_s0", 32'(bus.switching), 32'h81);
      for (int i = 1; i < 4; i++) begin
         tick();
         check("c07_m", 32'(bus.mux_out), 32'h22);
         check("c07_s", 32'(bus.switching), 32'h81);
      end
      tick();
      check("c07_end", 32'(bus.mux_out), 32'hA3);
      check("c07_end_s", 32'(bus.switching), 32'h00);
      bus.src_in = 32'h2010_0042;
      tick();
      check("c07_src1", 32'(bus.mux_out), 32'hA3);

      // reset in the middle of a dead-time on channel 3
      bus.sel_wr = 8'h08;
      bus.sel_wdata = 3'd2;
      tick();
      bus.sel_wr = '0;
      check("c3_gap", 32'(bus.switching), 32'h08);
      tick();
      check("c3_gap2", 32'(bus.switching), 32'h08);
      resetn = 1'b0;
      tick();
      check("c3_rst_s", 32'(bus.switching), 32'h00);
      check("c3_rst_sel", 32'(bus.sel_q), 32'h0);
      check("c3_rst_m", 32'(bus.mux_out), 32'h00);
      resetn = 1'b1;
      for (int i = 0; i < LAT; i++) tick();
      check("c3_rel_m", 32'(bus.mux_out), 32'h20);

      // dead-time-free instance
      b0.src_in = 8'b0000_0011;
      for (int i = 0; i < LAT; i++) tick();
      check("d0_pre", 32'(b0.mux_out), 32'h1);
      b0.sel_wr = 2'b01;
      b0.sel_wdata = 3'd1;
      tick();
      b0.sel_wr = '0;
      check("d0_wr_m", 32'(b0.mux_out), 32'h1);
      check("d0_wr_s", 32'(b0.switching), 32'h0);
      check("d0_wr_sel", 32'(b0.sel_q), 32'h01);
      b0.src_in = 8'b0000_0010;
      tick();
      check("d0_src1", 32'(b0.mux_out), 32'h1);
      b0.src_in = 8'b0000_0001;
      tick();
      check("d0_src0", 32'(b0.mux_out), 32'h0);
      b0.sel_wr = 2'b01;
      b0.sel_wdata = 3'd4;
      tick();
      b0.sel_wr = '0;
      check("d0_inv_sel", 32'(b0.sel_q), 32'h01);

      // source-to-output latency on channel 5
      bus.src_in = 32'h0010_0000;
      for (int i = 0; i < 4; i++) tick();
      bus.src_in = 32'h0;
      first = 0;
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (first == 0 && bus.mux_out[5] == 1'b0) first = k;
      end
      check("latency", 32'(first), 32'(LAT));

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end
endmodule
